// File: rtl/setn_release_seq_if.sv
// Request/status and per-bank drive bundle for setn_release_seq.
// SEQ_CNT is only present when SETN_SEQ_CNT_EN is defined.
interface setn_release_seq_if #(
    parameter int NBANK = 4
);
    logic             REQ;
    logic             BUSY;
    logic             DONE;
    logic [NBANK-1:0] SETN_OUT;
    logic [NBANK-1:0] CLK_EN;
`ifdef SETN_SEQ_CNT_EN
    logic [7:0]       SEQ_CNT;

    modport master (output REQ, input BUSY, DONE, SETN_OUT, CLK_EN, SEQ_CNT);
    modport slave  (input REQ, output BUSY, DONE, SETN_OUT, CLK_EN, SEQ_CNT);
`else
    modport master (output REQ, input BUSY, DONE, SETN_OUT, CLK_EN);
    modport slave  (input REQ, output BUSY, DONE, SETN_OUT, CLK_EN);
`endif
endinterface

// File: rtl/setn_release_seq.sv
// Set/release sequencer for banks of negative-edge set-type flops: holds SETN low, then staggers
// releases with a gated-clock guard window per bank. Optional sequence counter: SETN_SEQ_CNT_EN.
module setn_release_seq #(
    parameter int NBANK     = 4,
    parameter int PULSE_CYC = 4,
    parameter int STAGGER   = 2,
    parameter int GUARD     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    setn_release_seq_if.slave bus
);
    localparam int MAX_A = (PULSE_CYC > STAGGER) ? PULSE_CYC : STAGGER;
    localparam int MAX_B = (GUARD > NBANK) ? GUARD : NBANK;
    localparam int MAXV  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXV) + 1;

    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, FINISH} state_t;

    state_t           state, state_nxt;
    logic             pend, pend_nxt;
    logic [NBANK-1:0] setn_q, setn_nxt;
    logic [NBANK-1:0] clken_q, clken_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [CW-1:0]    pcnt, pcnt_nxt;
    logic [CW-1:0]    scnt, scnt_nxt;
    logic [CW-1:0]    bidx, bidx_nxt;
    logic [CW-1:0]    gcnt [NBANK];
    logic [CW-1:0]    gcnt_nxt [NBANK];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            pend    <= 1'b0;
            setn_q  <= '1;
            clken_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pcnt    <= '0;
            scnt    <= '0;
            bidx    <= '0;
            gcnt    <= '{default: '0};
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            setn_q  <= setn_nxt;
            clken_q <= clken_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            pcnt    <= pcnt_nxt;
            scnt    <= scnt_nxt;
            bidx    <= bidx_nxt;
            gcnt    <= gcnt_nxt;
        end
    end

    // Each released bank owns a guard down-counter; its clock re-enables when that counter expires.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        setn_nxt  = setn_q;
        clken_nxt = clken_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        pcnt_nxt  = pcnt;
        scnt_nxt  = scnt;
        bidx_nxt  = bidx;
        gcnt_nxt  = gcnt;

        if (bus.REQ && (state != IDLE)) begin
            pend_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.REQ || pend) begin
                    state_nxt = ASSERT;
                    pend_nxt  = 1'b0;
                    setn_nxt  = '0;
                    clken_nxt = '0;
                    busy_nxt  = 1'b1;
                    pcnt_nxt  = CW'(1);
                    gcnt_nxt  = '{default: '0};
                end
            end
            ASSERT: begin
                if (pcnt == CW'(PULSE_CYC)) begin
                    state_nxt   = RELEASE;
                    setn_nxt[0] = 1'b1;
                    gcnt_nxt[0] = CW'(GUARD);
                    bidx_nxt    = CW'(1);
                    scnt_nxt    = CW'(1);
                end else begin
                    pcnt_nxt = pcnt + CW'(1);
                end
            end
            RELEASE: begin
                if (bidx < CW'(NBANK)) begin
                    if (scnt == CW'(STAGGER)) begin
                        for (int i = 0; i < NBANK; i++) begin
                            if (bidx == CW'(i)) begin
                                setn_nxt[i] = 1'b1;
                                gcnt_nxt[i] = CW'(GUARD);
                            end
                        end
                        bidx_nxt = bidx + CW'(1);
                        scnt_nxt = CW'(1);
                    end else begin
                        scnt_nxt = scnt + CW'(1);
                    end
                end
                for (int i = 0; i < NBANK; i++) begin
                    if (gcnt[i] != '0) begin
                        gcnt_nxt[i] = gcnt[i] - CW'(1);
                        if (gcnt[i] == CW'(1)) begin
                            clken_nxt[i] = 1'b1;
                        end
                    end
                end
                if (gcnt[NBANK-1] == CW'(1)) begin
                    state_nxt = FINISH;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.SETN_OUT = setn_q;
    assign bus.CLK_EN   = clken_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

`ifdef SETN_SEQ_CNT_EN
    logic [7:0] seq_cnt;

    // Counts alongside the DONE pulse and sticks at 255.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seq_cnt <= '0;
        end else if (done_nxt && (seq_cnt != 8'hFF)) begin
            seq_cnt <= seq_cnt + 8'd1;
        end
    end

    assign bus.SEQ_CNT = seq_cnt;
`endif
endmodule

// File: doc/setn_release_seq.md
# setn_release_seq

Synchronous sequencer that drives the active-low SETN pins and clock-gate enables for up to 16 banks of negative-edge set-type flip-flops. On request it holds every bank in set for a programmable minimum pulse width, then releases banks one at a time. Each bank's clock stays gated around its release so the flop recovery/removal windows against the falling CLKN edge are never violated. It sits between the chip power/reset manager and the clock-gate cells feeding each flop bank.

## Interface
- NBANK, 4, number of flop banks controlled (1..16)
- PULSE_CYC, 4, cycles SETN is held low before the first release (>=1)
- STAGGER, 2, cycles between consecutive bank releases (>=1)
- GUARD, 2, cycles a bank's clock stays gated after its SETN rises (>=1)

Ports:
- CLK  input  1  sequencer clock; all state changes on its rising edge
- RST  input  1  reset, synchronous, active-high
- REQ  input  1  request a set/release sequence; sampled every edge
- BUSY  output  1  high while a sequence is in progress
- DONE  output  1  one-cycle pulse when the last bank's clock is re-enabled
- SETN_OUT  output  NBANK  per-bank SETN drive; bit i goes to bank i
- CLK_EN  output  NBANK  per-bank clock-gate enable; 0 holds bank clock high, so no falling edge reaches the bank
- SEQ_CNT  output  8  completed-sequence count (present only with SETN_SEQ_CNT_EN)

## Operation
- All outputs are registered.
- Reset values: SETN_OUT all 1, CLK_EN all 1, BUSY 0, DONE 0, pending flag 0, state IDLE.
- States: IDLE, ASSERT, RELEASE, FINISH.
- IDLE -> ASSERT when REQ or the pending flag is high; the pending flag clears on that edge.
- ASSERT: SETN_OUT = 0 and CLK_EN = 0 for all banks; BUSY = 1; a cycle counter runs for PULSE_CYC cycles, then the block moves to RELEASE.
- RELEASE: bank index b starts at 0.
  - SETN_OUT[b] rises, then b increments every STAGGER cycles.
  - CLK_EN[b] rises GUARD cycles after SETN_OUT[b].
  - Release and re-enable counters for different banks run overlapped; a single down-counter per bank or a shared schedule is acceptable.
- FINISH is entered on the edge where CLK_EN[NBANK-1] rises. On that same edge DONE = 1 and BUSY = 0. On the next edge the block returns to IDLE and DONE = 0.
- REQ while BUSY sets the pending flag; extra requests merge into that one flag (one-deep, no count).
- A pending request starts a new sequence on the first IDLE edge, so it begins 1 cycle after DONE.
- Invariant: CLK_EN[i] = 1 implies SETN_OUT[i] = 1, at every edge.
- RST mid-sequence: the next edge restores all reset values, the pending flag is discarded, and no DONE pulse is produced. SETN and CLK_EN rise together in this case; the system reset manager owns that hazard.

## Timing
- REQ sampled at edge t0 (IDLE): SETN_OUT and CLK_EN go all-0 and BUSY goes 1 after t0.
- SETN_OUT[i] rises after edge t0 + PULSE_CYC + i*STAGGER.
- CLK_EN[i] rises after edge t0 + PULSE_CYC + i*STAGGER + GUARD.
- DONE is high for exactly one cycle, after edge tD = t0 + PULSE_CYC + (NBANK-1)*STAGGER + GUARD. With defaults, tD = t0 + 12.
- Minimum SETN low width for bank i is PULSE_CYC + i*STAGGER cycles.
- Back-to-back sequences (pending or REQ held high): next ASSERT at tD + 2. SETN_OUT stays high for at least 1 cycle between sequences.
- NBANK = 1: no stagger; tD = t0 + PULSE_CYC + GUARD.
- Counter widths: clog2 of the largest of PULSE_CYC, STAGGER, GUARD, NBANK, plus 1.

## Configuration
- SETN_SEQ_CNT_EN defined:
  - SEQ_CNT port exists.
  - Increments by 1 on each DONE pulse and saturates at 255.
  - Cleared by RST.
- SETN_SEQ_CNT_EN undefined: no SEQ_CNT port, no counter logic; all other behaviour is identical.

## Test plan
- Defaults, single REQ pulse at t0 -> SETN_OUT 4'b0000 during cycles t0+1..t0+4. Bits rise at t0+4, +6, +8, +10. CLK_EN bits rise at t0+6, +8, +10, +12. DONE is a one-cycle pulse after t0+12. BUSY is low after t0+12.
- REQ pulsed 3 times during BUSY -> exactly one extra sequence, ASSERT at tD+2, then IDLE with no third sequence.
- RST asserted at t0+7 -> after that edge: SETN_OUT = 4'b1111, CLK_EN = 4'b1111, BUSY 0, no DONE pulse. A following REQ gives a full nominal sequence.
- NBANK=1, PULSE_CYC=1, GUARD=1 -> SETN low for 1 cycle; DONE after t0+2.
- Invariant checker on all runs: never CLK_EN[i] = 1 with SETN_OUT[i] = 0. With SETN_SEQ_CNT_EN, SEQ_CNT reads 255 after 300 sequences.
